cntr_bank: RTL
==============

Name: cntr_bank

Overview:
- Parametrised successor to the core's fixed counter block.
- Holds NUM_CNTRS counters, each CNTR_WIDTH bits wide: cycle, instret, and NUM_CNTRS-2 event counters.
- Adds software read/write over a WORD_SIZE-wide port, a per-counter inhibit mask and sticky overflow flags.
- Sits beside the control and datapath in the core. The datapath reads and writes it for counter/CSR instructions.

Parameters:
- WORD_SIZE, 32: access port data width.
- CNTR_WIDTH, 64: counter width; must be WORD_SIZE or 2*WORD_SIZE.
- NUM_CNTRS, 4: total counters, 2..30. Index 0 = cycle, 1 = instret, 2.. = events.
- ADDR_W, 6: access address width.

Ports:
- clk, in, 1: clock; all state updates on posedge.
- rst, in, 1: synchronous, active-low reset.
- retire, in, 1: one-cycle pulse per retired instruction.
- event_i, in, NUM_CNTRS-2: per-cycle event strobes; bit k drives counter k+2.
- rd_en, in, 1: read request.
- wr_en, in, 1: write request.
- addr, in, ADDR_W: addr[0] = half select (1 = high word), addr[ADDR_W-1:1] = index.
- wdata, in, WORD_SIZE: write data.
- rd_valid, out, 1: read data valid.
- rd_data, out, WORD_SIZE: read data.
- ovf, out, NUM_CNTRS: sticky overflow flags.

Behaviour:
- Reset (rst==0 at posedge), all cleared to 0: counters, inhibit, ovf, rd_valid, rd_data. Reset mid-operation aborts any pending read; rd_valid is 0 the next cycle.
- Increment: counter i increments by 1 at posedge when its source is 1 and inhibit[i]==0.
  - Source for cycle: constant 1.
  - Source for instret: retire.
  - Source for event k: event_i[k].
- Wrap: all-ones + 1 -> 0 and sets ovf[i]. ovf[i] stays set until any write to counter i, or reset.
- Index map:
  - 0..NUM_CNTRS-1: counters.
  - 30: inhibit register. Low NUM_CNTRS bits are R/W; upper bits read 0; addr[0] ignored.
  - 31: ovf register. Read-only; writes ignored; addr[0] ignored.
  - Any other index reads 0; writes are ignored.
- Half select when CNTR_WIDTH==WORD_SIZE: addr[0]=1 reads 0 and writes are ignored.
- Write (wr_en=1): the addressed half is loaded with wdata and the other half is kept. That counter does not increment in that cycle; write has priority over increment and carry. Its ovf bit is cleared.
- Write to inhibit takes effect from the next cycle. The increment in the write cycle uses the old mask.
- Read (rd_en=1): registered, 1-cycle latency. rd_valid=1 and rd_data = the addressed word as held before the same posedge's update, i.e. pre-increment and pre-write.
  - rd_valid=0 when no read was issued. rd_data then holds its last value.
  - Back-to-back reads are accepted every cycle.
- rd_en and wr_en together on the same address: the read returns the old value and the write is applied.
- 64-bit coherence is software's responsibility (read hi, lo, hi). No snapshot logic.
- No arithmetic beyond +1 modulo 2^CNTR_WIDTH. Low-to-high carry is within the same cycle.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, then rst=1 for 10 cycles; read index0 lo -> rd_valid 1 cycle later. rd_data equals the cycle count at the read edge (10), hi reads 0.
- Carry and overflow: write counter2 lo=0xFFFFFFFF and hi=0xFFFFFFFF. Pulse event_i[0] once -> counter2 reads 0/0, ovf[2]=1. Write counter2 lo=5 -> ovf[2]=0, lo=5.
- Low-half carry: write counter1 lo=0xFFFFFFFF, hi=0. One retire pulse -> lo=0, hi=1, ovf[1]=0.
- Inhibit: write index30=0x3. Run 20 cycles with retire every cycle -> counters 0 and 1 frozen. Write index30=0 -> counter0 resumes +1 per cycle.
- Write vs increment collision: write counter0 lo=100 in a cycle where cycle would increment -> next-cycle read returns 100, the following read 101. A same-cycle read of index0 returns the pre-write value.
- Unmapped and read-only: write to index 29 and to index31 -> no state change. Reads of both return 0 and the current ovf vector respectively. Asserting rst=0 during a pending read -> rd_valid=0 the next cycle.

Source files
------------

// File: rtl/cntr_bank.sv
// cntr_bank: bank of NUM_CNTRS free-running counters (cycle, instret, events) with inhibit mask and sticky overflow.
// Latency: reads return 1 cycle after rd_en; writes and increments land at the same posedge.
// Backpressure: none; a read or write is accepted every cycle.
//
// Ports:
//   clk, rst (sync, active-low) | retire, event_i : increment sources
//   rd_en, wr_en, addr, wdata   : access port (addr[0] = high-word select, addr[ADDR_W-1:1] = index)
//   rd_valid, rd_data           : registered read return
//   ovf                         : sticky per-counter overflow flags
module cntr_bank #(
  parameter int WORD_SIZE  = 32,
  parameter int CNTR_WIDTH = 64,
  parameter int NUM_CNTRS  = 4,
  parameter int ADDR_W     = 6,
  localparam int EV_W      = (NUM_CNTRS > 2) ? NUM_CNTRS - 2 : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 retire,
  input  logic [EV_W-1:0]      event_i,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [NUM_CNTRS-1:0] ovf
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] INH_IDX = IDX_W'(30);
  localparam logic [IDX_W-1:0] OVF_IDX = IDX_W'(31);
  localparam bit DOUBLE = (CNTR_WIDTH == 2 * WORD_SIZE);

  logic [IDX_W-1:0]      idx;
  logic                  hi_sel;
  logic                  half_ok;
  logic [CNTR_WIDTH-1:0] cntr_q [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] cntr_d [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0] merged [NUM_CNTRS];
  logic [NUM_CNTRS-1:0]  src;
  logic [NUM_CNTRS-1:0]  inh_q;
  logic [NUM_CNTRS-1:0]  ovf_q;
  logic [NUM_CNTRS-1:0]  ovf_d;
  logic [CNTR_WIDTH-1:0] cnt_sel;
  logic [WORD_SIZE-1:0]  cnt_word;
  logic [WORD_SIZE-1:0]  rd_word;

  assign idx    = addr[ADDR_W-1:1];
  assign hi_sel = addr[0];
  // With single-word counters the high half does not exist: it reads 0 and ignores writes.
  assign half_ok = DOUBLE || !hi_sel;
  assign ovf     = ovf_q;

  // Per-counter increment source and the write-merged value (addressed half replaced, other half kept).
  for (genvar i = 0; i < NUM_CNTRS; i++) begin : g_cntr
    if (i == 0) begin : g_cyc
      assign src[i] = 1'b1;
    end else if (i == 1) begin : g_ret
      assign src[i] = retire;
    end else begin : g_evt
      assign src[i] = event_i[i-2];
    end

    if (DOUBLE) begin : g_dbl
      assign merged[i] = hi_sel ? {wdata, cntr_q[i][WORD_SIZE-1:0]}
                                : {cntr_q[i][CNTR_WIDTH-1:WORD_SIZE], wdata};
    end else begin : g_sgl
      assign merged[i] = CNTR_WIDTH'(wdata);
    end
  end

  // Next state: a write beats the increment and clears the sticky flag; the
  // increment uses the mask as held before this edge.
  always_comb begin
    for (int i = 0; i < NUM_CNTRS; i++) begin
      cntr_d[i] = cntr_q[i];
      ovf_d[i]  = ovf_q[i];
      if (wr_en && half_ok && (idx == IDX_W'(i))) begin
        cntr_d[i] = merged[i];
        ovf_d[i]  = 1'b0;
      end else if (src[i] && !inh_q[i]) begin
        cntr_d[i] = cntr_q[i] + CNTR_WIDTH'(1);
        if (&cntr_q[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  // Read path sees pre-update state, so a same-cycle write returns the old value.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (idx == IDX_W'(i)) cnt_sel = cntr_q[i];
    end
  end

  if (DOUBLE) begin : g_rd_dbl
    assign cnt_word = hi_sel ? cnt_sel[CNTR_WIDTH-1:WORD_SIZE] : cnt_sel[WORD_SIZE-1:0];
  end else begin : g_rd_sgl
    assign cnt_word = hi_sel ? '0 : cnt_sel[WORD_SIZE-1:0];
  end

  always_comb begin
    rd_word = '0;
    if (idx == INH_IDX)                 rd_word = WORD_SIZE'(inh_q);
    else if (idx == OVF_IDX)            rd_word = WORD_SIZE'(ovf_q);
    else if (int'(idx) < NUM_CNTRS)     rd_word = cnt_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNTRS; i++) cntr_q[i] <= '0;
      inh_q    <= '0;
      ovf_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_CNTRS; i++) cntr_q[i] <= cntr_d[i];
      ovf_q    <= ovf_d;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_word;
      if (wr_en && idx == INH_IDX) inh_q <= wdata[NUM_CNTRS-1:0];
    end
  end

endmodule
